// File: rtl/ledg_pattern_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ledg_pattern_sched: round-robin sharing of the LEDG pin among NREQ        |
// | requesters, each pattern played MSB first followed by a one-tick gap.     |
// | Optional macro LEDG_STATS_EN adds saturating per-requester grant counts.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ledg_pattern_sched #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   PAT,
  output logic [NREQ-1:0]         GNT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    LEDG,
  output logic [NREQ*8-1:0]       SERVED
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [TW-1:0]    presc;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;

  logic             found;
  logic [PW-1:0]    win;
  logic [WIDTH-1:0] win_pat;
  logic [NREQ-1:0]  win_onehot;
  logic [WIDTH-1:0] shreg_next;
  int               idx;

  // Scan offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_pat = '0;
    idx     = 0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      idx = (int'(ptr) + o) % NREQ;
      if (REQ[idx]) begin
        found   = 1'b1;
        win     = PW'(idx);
        win_pat = PAT[idx*WIDTH +: WIDTH];
      end
    end
    win_onehot = NREQ'(1) << win;
    shreg_next = shreg << 1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= IDLE;
      ptr     <= '0;
      presc   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      GNT     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      LEDG    <= 1'b0;
    end else begin
      GNT  <= '0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            shreg   <= win_pat;
            GNT     <= win_onehot;
            BUSY    <= 1'b1;
            LEDG    <= win_pat[WIDTH-1];
            presc   <= '0;
            bit_cnt <= '0;
            ptr     <= (win == PTR_LAST) ? '0 : win + 1'b1;
            state   <= PLAY;
          end else begin
            LEDG <= 1'b0;
            BUSY <= 1'b0;
          end
        end
        PLAY: begin
          if (presc == TICK_LAST) begin
            presc <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              LEDG    <= 1'b0;
              state   <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_next;
              LEDG    <= shreg_next[WIDTH-1];
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        GAP: begin
          if (presc == TICK_LAST) begin
            presc <= '0;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEDG_STATS_EN
  logic [7:0] served_q [NREQ];

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int i = 0; i < NREQ; i++) served_q[i] <= '0;
    end else if (state == IDLE && found && served_q[win] != 8'hFF) begin
      served_q[win] <= served_q[win] + 8'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_served
    assign SERVED[g*8 +: 8] = served_q[g];
  end
`else
  assign SERVED = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ledg_pattern_sched.sv
`default_nettype none
// tb_ledg_pattern_sched: scoreboard bench for ledg_pattern_sched (TICK_DIV=4 main
// instance plus a TICK_DIV=1 instance); model predicts grants, LED stream, DONE timing.
module tb_ledg_pattern_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int T    = 4;
  localparam int TXN  = (W + 1) * T;

  logic              clk = 1'b0;
  logic              rst_x = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] pat = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy, done, ledg;
  logic [NREQ*8-1:0] served;

  logic [NREQ-1:0]   req_b = '0;
  logic [NREQ*W-1:0] pat_b = '0;
  logic [NREQ-1:0]   gnt_b;
  logic              busy_b, done_b, ledg_b;
  logic [NREQ*8-1:0] served_b;

  ledg_pattern_sched #(.NREQ(NREQ), .WIDTH(W), .TICK_DIV(T)) u_dut (
    .CLK(clk), .RST_X(rst_x), .REQ(req), .PAT(pat), .GNT(gnt),
    .BUSY(busy), .DONE(done), .LEDG(ledg), .SERVED(served));

  ledg_pattern_sched #(.NREQ(NREQ), .WIDTH(W), .TICK_DIV(1)) u_dut_t1 (
    .CLK(clk), .RST_X(rst_x), .REQ(req_b), .PAT(pat_b), .GNT(gnt_b),
    .BUSY(busy_b), .DONE(done_b), .LEDG(ledg_b), .SERVED(served_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    pat;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   next_eval = 0;
  int   m_ptr = 0;
  int   served_m[NREQ];
  bit   hs = 1'b1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ*8-1:0] exp_served();
    logic [NREQ*8-1:0] v;
    v = '0;
`ifdef LEDG_STATS_EN
    for (int i = 0; i < NREQ; i++) v[i*8 +: 8] = 8'(served_m[i]);
`endif
    return v;
  endfunction

  // One clock: reference model decides at the edge, requesters react at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_x && cyc >= next_eval && req != '0) begin
      for (int o = 0; o < NREQ; o++) begin
        int k;
        k = (m_ptr + o) % NREQ;
        if (req[k]) begin
          exp_t e;
          e.gnt    = '0;
          e.gnt[k] = 1'b1;
          e.pat    = pat[k*W +: W];
          e.cyc    = cyc;
          sbq.push_back(e);
          m_ptr     = (k + 1) % NREQ;
          next_eval = cyc + TXN + 1;
          if (served_m[k] < 255) served_m[k]++;
          break;
        end
      end
    end
    @(negedge clk);
    if (hs) req = req & ~gnt;
  endtask

  task automatic wait_idle();
    while (cyc < next_eval - 1) tick();
    tick();
  endtask

  task automatic pulse_reset();
    #2 rst_x = 1'b0;
    #1 check("reset_async", {gnt, busy, done, ledg, served}, '0);
    sbq.delete();
    m_ptr     = 0;
    next_eval = 0;
    for (int i = 0; i < NREQ; i++) served_m[i] = 0;
    req = '0;
    tick();
    tick();
    #2 rst_x = 1'b1;
  endtask

  // Monitor: pops an expectation on each grant and follows the LED stream to DONE.
  initial begin
    exp_t            cur;
    exp_t            junk;
    int              j;
    bit              active;
    logic [NREQ-1:0] eg;
    logic            el;
    active = 1'b0;
    j      = 0;
    forever begin
      @(negedge clk);
      if (!rst_x) begin
        active = 1'b0;
        continue;
      end
      check("served", served, exp_served());
      if (!active) begin
        if (gnt != '0) begin
          if (sbq.size() == 0) begin
            check("gnt_unexpected", gnt, '0);
          end else begin
            cur = sbq.pop_front();
            check("gnt_cycle", cyc, cur.cyc);
            active = 1'b1;
            j      = 0;
          end
        end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          check("gnt_missing", gnt, sbq[0].gnt);
          junk = sbq.pop_front();
        end
      end
      if (active) begin
        eg = (j == 0) ? cur.gnt : '0;
        el = (j < W * T) ? cur.pat[W - 1 - j / T] : 1'b0;
        check("stream", {gnt, busy, done, ledg}, {eg, (j < TXN), (j == TXN), el});
        j++;
        if (j > TXN) active = 1'b0;
      end else begin
        check("idle", {gnt, busy, done, ledg}, '0);
      end
    end
  end

  initial begin
    bit         found_b;
    logic [W-1:0] pv;
    for (int i = 0; i < NREQ; i++) served_m[i] = 0;

    // Reset state and idle with no requests.
    #3 check("reset_hold", {gnt, busy, done, ledg, served}, '0);
    @(negedge clk);
    #2 rst_x = 1'b1;
    repeat (4) tick();

    // Single request, A5 on requester 2.
    pat = '0;
    pat[2*W +: W] = 8'hA5;
    req = 4'b0100;
    wait_idle();

    // All requesting continuously: rotation and back-to-back timing.
    hs = 1'b0;
    for (int i = 0; i < NREQ; i++) pat[i*W +: W] = 8'(8'h31 * (i + 1) + 8'h0C);
    req = 4'b1111;
    repeat (5 * (TXN + 1)) tick();
    req = '0;
    hs  = 1'b1;
    wait_idle();

    // All-ones then all-zeros patterns.
    pat = '0;
    pat[1*W +: W] = 8'hFF;
    pat[3*W +: W] = 8'h00;
    req = 4'b1010;
    repeat (2 * (TXN + 1) + 2) tick();
    wait_idle();

    // TICK_DIV=1 instance: DONE nine cycles after grant.
    pv = 8'h96;
    pat_b[1*W +: W] = pv;
    req_b = 4'b0010;
    found_b = 1'b0;
    for (int i = 0; i < 4 && !found_b; i++) begin
      tick();
      if (gnt_b != '0) found_b = 1'b1;
    end
    check("t1_gnt", gnt_b, 4'b0010);
    req_b = '0;
    for (int j = 0; j <= W + 1; j++) begin
      check("t1_stream", {busy_b, done_b, ledg_b},
            {(j < W + 1), (j == W + 1), (j < W) ? pv[W - 1 - j] : 1'b0});
      tick();
    end

    // Randomized traffic with handshake and PAT churn after grants.
    repeat (2500) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 3) == 0) pat[i*W +: W] = 8'($urandom);
      tick();
    end
    req = '0;
    wait_idle();

    // Reset in the middle of a pattern, then pointer restarts at 0.
    pat[2*W +: W] = 8'hFF;
    req = 4'b0100;
    tick();
    repeat (3 * T + 1) tick();
    pulse_reset();
    pat[0*W +: W] = 8'h3C;
    pat[2*W +: W] = 8'hC3;
    req = 4'b0101;
    repeat (2 * (TXN + 1) + 2) tick();
    wait_idle();

    // Long run on requester 1 for counter saturation.
    hs  = 1'b0;
    req = 4'b0010;
    repeat (260 * (TXN + 1)) tick();
    req = '0;
    hs  = 1'b1;
    wait_idle();
    check("served_final", served, exp_served());
    check("queue_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
